// File: rtl/sprite_loader.sv
// sprite_loader: shadow sprite buffer committed to the active buffer at frame start.
module sprite_loader #(
   parameter int SPR_W    = 4,
   parameter int SPR_H    = 4,
   parameter int PIX_BITS = 4,
   parameter int POS_W    = 10
) (
   input  logic                                   vga_clk,
   input  logic                                   rst_n,
   input  logic                                   wr_valid,
   output logic                                   wr_ready,
   input  logic [$clog2(SPR_W*SPR_H+4)-1:0]       wr_addr,
   input  logic [POS_W-1:0]                       wr_data,
   input  logic                                   frame_start,
   input  logic [$clog2(SPR_W*SPR_H)-1:0]         rd_idx,
   output logic [PIX_BITS-1:0]                    rd_pixel,
   output logic [POS_W-1:0]                       spr_row,
   output logic [POS_W-1:0]                       spr_col,
   output logic                                   spr_en,
   output logic                                   busy,
   output logic                                   commit_done
);
   localparam int N      = SPR_W*SPR_H;
   localparam int IDX_W  = $clog2(N);
   localparam int ADDR_W = $clog2(N+4);
   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] PENDING = 2'd1;
   localparam logic [1:0] COPY    = 2'd2;
   logic [1:0]          state;
   logic [IDX_W-1:0]    idx;
   logic [PIX_BITS-1:0] sh [N];
   logic [PIX_BITS-1:0] act [N];
   logic [POS_W-1:0]    sh_row, sh_col;
   logic                sh_en;
   assign wr_ready = state == IDLE;
   assign busy     = state != IDLE;
   always_ff @(posedge vga_clk or negedge rst_n)
      if (!rst_n) begin
         state       <= IDLE;
         idx         <= '0;
         commit_done <= 1'b0;
         rd_pixel    <= '0;
         sh_row      <= '0;
         sh_col      <= '0;
         sh_en       <= 1'b0;
         spr_row     <= '0;
         spr_col     <= '0;
         spr_en      <= 1'b0;
         for (int i = 0; i < N; i++) begin
            sh[i]  <= '0;
            act[i] <= '0;
         end
      end else begin
         commit_done <= 1'b0;
         rd_pixel    <= int'(rd_idx) < N ? act[rd_idx] : '0;
         if (state == IDLE && wr_valid) begin
            if (int'(wr_addr) < N) sh[wr_addr[IDX_W-1:0]] <= wr_data[PIX_BITS-1:0];
            else if (wr_addr == ADDR_W'(N))   sh_row <= wr_data;
            else if (wr_addr == ADDR_W'(N+1)) sh_col <= wr_data;
            else if (wr_addr == ADDR_W'(N+2)) state  <= PENDING;
            else if (wr_addr == ADDR_W'(N+3)) sh_en  <= wr_data[0];
         end
         if (state == PENDING && frame_start) begin
            state <= COPY;
            idx   <= '0;
         end
         if (state == COPY) begin
            act[idx] <= sh[idx];
            idx      <= idx + 1'b1;
            if (int'(idx) == N-1) begin
               spr_row     <= sh_row;
               spr_col     <= sh_col;
               spr_en      <= sh_en;
               state       <= IDLE;
               commit_done <= 1'b1;
            end
         end
      end
endmodule

// File: tb/tb_sprite_loader.sv
// tb_sprite_loader: table-driven and scoreboard checks of the sprite commit path.
module tb_sprite_loader;
   localparam int N = 16;
   localparam logic [4:0] A_ROW    = 5'd16;
   localparam logic [4:0] A_COL    = 5'd17;
   localparam logic [4:0] A_COMMIT = 5'd18;
   localparam logic [4:0] A_EN     = 5'd19;
   logic       vga_clk = 1'b0, rst_n = 1'b0, wr_valid = 1'b0, frame_start = 1'b0;
   logic       wr_ready, spr_en, busy, commit_done;
   logic [4:0] wr_addr = '0;
   logic [9:0] wr_data = '0;
   logic [3:0] rd_idx = '0, rd_pixel;
   logic [9:0] spr_row, spr_col;
   int         n_cmp = 0, n_bad = 0, k;
   int         exp_q[$];
   logic [3:0] m_sh [N], m_act [N];
   logic [9:0] m_row = '0, m_col = '0;
   logic       m_en = 1'b0;
   typedef struct {logic [3:0] idx; logic [3:0] pix;} vec_t;
   vec_t       vecs [N];
   always #5 vga_clk = ~vga_clk;
   sprite_loader dut (
      .vga_clk(vga_clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .wr_addr(wr_addr), .wr_data(wr_data), .frame_start(frame_start), .rd_idx(rd_idx),
      .rd_pixel(rd_pixel), .spr_row(spr_row), .spr_col(spr_col), .spr_en(spr_en),
      .busy(busy), .commit_done(commit_done)
   );
   task automatic step();
      @(posedge vga_clk);
      #1;
   endtask
   task automatic chk(input string nm, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
      end
   endtask
   task automatic rd_chk(input int i);
      rd_idx = 4'(i);
      exp_q.push_back(int'(m_act[i]));
      step();
      chk("rd_pixel", int'(rd_pixel), exp_q.pop_front());
   endtask
   task automatic wr(input logic [4:0] a, input logic [9:0] d);
      int n = 0;
      wr_addr  = a;
      wr_data  = d;
      wr_valid = 1'b1;
      while (!wr_ready && n < 200) begin
         step();
         n++;
      end
      chk("wr_ready_wait", int'(wr_ready), 1);
      step();
      wr_valid = 1'b0;
      if (a < 5'd16) m_sh[a[3:0]] = d[3:0];
      else if (a == A_ROW) m_row = d;
      else if (a == A_COL) m_col = d;
   endtask
   task automatic run_copy(input int fs_at);
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      k = 0;
      while (!commit_done && k < 40) begin
         frame_start = (k == fs_at);
         step();
         frame_start = 1'b0;
         k++;
      end
      chk("copy_len", k, 16);
      chk("spr_row", int'(spr_row), int'(m_row));
      chk("spr_col", int'(spr_col), int'(m_col));
      chk("spr_en", int'(spr_en), int'(m_en));
      for (int i = 0; i < N; i++) m_act[i] = m_sh[i];
      step();
      chk("done_pulse_once", int'(commit_done), 0);
      chk("busy_after_copy", int'(busy), 0);
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      for (int i = 0; i < N; i++) begin
         m_sh[i]      = '0;
         m_act[i]     = '0;
         vecs[i].idx  = 4'(i);
         vecs[i].pix  = 4'(i) ^ 4'hA;
      end
      step();
      step();
      chk("rst_rd_pixel", int'(rd_pixel), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_commit_done", int'(commit_done), 0);
      chk("rst_spr_row", int'(spr_row), 0);
      chk("rst_spr_col", int'(spr_col), 0);
      chk("rst_spr_en", int'(spr_en), 0);
      rst_n = 1'b1;
      step();
      chk("wr_ready_after_rst", int'(wr_ready), 1);
      for (int i = 0; i < N; i++) rd_chk(i);
      for (int i = 0; i < N; i++) wr(5'(i), 10'(4'(i) ^ 4'hA));
      wr(A_ROW, 10'd100);
      wr(A_COL, 10'd200);
      wr(A_EN, 10'd1);
      m_en = 1'b1;
      wr(A_COMMIT, 10'd0);
      for (int c = 0; c < 50; c++) begin
         chk("pending_busy", int'(busy), 1);
         chk("pending_ready", int'(wr_ready), 0);
         chk("pending_spr_en", int'(spr_en), 0);
         step();
      end
      rd_chk(5);
      run_copy(-1);
      for (int i = 0; i < N; i++) begin
         rd_idx = vecs[i].idx;
         exp_q.push_back(int'(vecs[i].pix));
         step();
         chk("tbl_rd_pixel", int'(rd_pixel), exp_q.pop_front());
      end
      wr(A_COMMIT, 10'd0);
      wr_addr  = 5'd3;
      wr_data  = 10'd7;
      wr_valid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         step();
         chk("held_not_ready", int'(wr_ready), 0);
      end
      run_copy(-1);
      wr_valid = 1'b0;
      m_sh[3] = 4'd7;
      rd_chk(3);
      chk("held_pix3_active", int'(rd_pixel), 9);
      wr(A_COMMIT, 10'd0);
      run_copy(-1);
      rd_chk(3);
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      chk("idle_fs_busy", int'(busy), 0);
      for (int c = 0; c < 20; c++) begin
         step();
         chk("idle_fs_no_done", int'(commit_done), 0);
      end
      wr(5'd0, 10'd5);
      wr(A_COMMIT, 10'd0);
      run_copy(5);
      for (int c = 0; c < 20; c++) begin
         step();
         chk("no_extra_done", int'(commit_done), 0);
      end
      rd_chk(0);
      wr(A_COMMIT, 10'd0);
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      for (int c = 0; c < 7; c++) step();
      rst_n = 1'b0;
      #1;
      chk("midcopy_rst_done", int'(commit_done), 0);
      chk("midcopy_rst_busy", int'(busy), 0);
      chk("midcopy_rst_spr_en", int'(spr_en), 0);
      chk("midcopy_rst_row", int'(spr_row), 0);
      step();
      rst_n = 1'b1;
      for (int i = 0; i < N; i++) begin
         m_sh[i]  = '0;
         m_act[i] = '0;
      end
      step();
      chk("ready_after_midrst", int'(wr_ready), 1);
      for (int i = 0; i < N; i++) begin
         rd_chk(i);
         chk("midrst_no_done", int'(commit_done), 0);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
